tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
Sequences TLB management instructions (tlbsrch, tlbrd, tlbwr, tlbfill, invtlb) onto the tlb block's write, read, invtlb and search-port-1 interfaces.
- Accepts one op at a time from the MEM stage via a valid/ready handshake.
- Arbitrates TLB search port 1 between the load/store unit and tlbsrch.
- Returns a one-cycle result pulse for CSR update (TLBIDX/TLBEHI/TLBELO/ASID).

Parameters:
TLBNUM, 16, number of TLB entries (power of two)
IDXW, $clog2(TLBNUM), index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op_valid  in  1  op request
op_ready  out  1  controller can accept an op (high only in IDLE)
op_code  in  3  0 srch, 1 rd, 2 wr, 3 fill, 4 inv; 5-7 illegal
op_inv_code  in  5  invtlb opcode
op_inv_asid  in  10  invtlb asid operand
op_inv_vppn  in  19  invtlb vppn operand
csr_index  in  IDXW  TLBIDX.index
csr_entry  in  89  packed CSR entry: [88]e(=~NE) [87:69]vppn [68:63]ps [62:53]asid [52]g [51:32]ppn0 [31:30]plv0 [29:28]mat0 [27]d0 [26]v0 [25:6]ppn1 [5:4]plv1 [3:2]mat1 [1]d1 [0]v1
lsu_s1_req  in  1  LSU wants search port 1
lsu_s1_vppn/lsu_s1_va_bit12/lsu_s1_asid  in  19/1/10  LSU search key
lsu_s1_gnt  out  1  LSU owns port 1 this cycle
tlb_s1_vppn/tlb_s1_va_bit12/tlb_s1_asid  out  19/1/10  to tlb search port 1
tlb_s1_found/tlb_s1_index  in  1/IDXW  from tlb
tlb_we/tlb_w_index/tlb_w_entry  out  1/IDXW/89  to tlb write port (entry unpacked by parent)
tlb_r_index  out  IDXW  to tlb read port
tlb_r_entry  in  89  packed tlb read data, same layout
tlb_inv_valid/tlb_inv_op/tlb_inv_asid/tlb_inv_vppn  out  1/5/10/19  to tlb invtlb port
res_valid  out  1  one-cycle result pulse
res_found  out  1  srch hit
res_index  out  IDXW  srch hit index
res_entry  out  89  rd data
res_ine  out  1  illegal op / illegal invtlb opcode

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state IDLE, fill_ptr=0, every registered output 0. Mid-op reset aborts the op: no tlb_we or tlb_inv_valid in the following cycle, and no res_valid.
- Accept: op_valid&&op_ready at cycle T latches op_code, inv operands, csr_index and csr_entry. IDLE->EXEC.
- EXEC, cycle T+1 (exactly one cycle). Actions by op:
  - srch: tlb_s1_* = {csr_entry.vppn, 0, csr_entry.asid}. lsu_s1_gnt=0. Registers tlb_s1_found/tlb_s1_index.
  - rd: tlb_r_index = latched index. Registers tlb_r_entry. If r_entry.e==0, res_entry is all zero.
  - wr: tlb_we=1, w_index = latched index, w_entry = latched csr_entry.
  - fill: tlb_we=1, w_index = fill_ptr. fill_ptr increments mod TLBNUM (TLBNUM-1 -> 0) at the end of the cycle.
  - inv: if inv_code<=6, tlb_inv_valid=1 with latched operands. Otherwise no pulse and res_ine=1.
  - op_code 5-7: no TLB action, res_ine=1.
- EXEC->RESP. In RESP (T+2): res_valid=1 with registered results, then RESP->IDLE. op_ready returns high at T+3, so at most one op per 3 cycles. A write completes before any following srch or rd.
- Result fields: res_found/res_index are 0 unless the op is srch with a hit. res_entry is 0 unless the op is rd. res_ine is 0 except for the illegal cases above.
- tlb_we and tlb_inv_valid are never asserted in the same cycle, and each pulses for exactly one cycle per op.
- Port-1 arbitration: when not (EXEC && srch), the tlb_s1_* outputs pass through lsu_s1_* and lsu_s1_gnt = lsu_s1_req. tlbsrch wins unconditionally during its EXEC cycle.
- op_valid held while op_ready=0 has no effect. The latched op is immune to later changes of the op and csr inputs.

Test Plan:
1. wr: csr_index=5, entry{e=1, vppn=0x12345, ps=12, asid=3, g=0, ppn0=0xABCDE, v0=1} -> tlb_we at T+1, w_index=5. Then srch with vppn=0x12345, asid=3 -> res_valid at T+2, res_found=1, res_index=5.
2. Four fills after reset (TLBNUM=16) -> w_index 0,1,2,3. After 16 fills the 17th writes index 0 (wrap).
3. rd index 5 after test 1 -> res_entry equals the written entry. rd of a never-written index with e=0 -> res_entry=0.
4. inv op=5, asid=3, vppn=0x12345 -> tlb_inv_valid one cycle with operands. A subsequent srch gives res_found=0. inv op=9 -> no tlb_inv_valid, res_ine=1.
5. lsu_s1_req held high across a srch -> lsu_s1_gnt=0 only in the EXEC cycle, and tlb_s1_vppn=csr vppn there. op_code=7 -> res_ine=1 with no TLB pulse.
6. Assert reset in the EXEC cycle of a wr -> no tlb_we, no res_valid, op_ready=1 after reset, fill_ptr=0.

Source files
------------

// File: rtl/tlb_op_ctrl_if.sv
// Op request / result bundle between the MEM stage and tlb_op_ctrl.
// Ports: master = MEM stage (issues op with CSR operands, receives result pulse),
//        slave  = tlb_op_ctrl (accepts op when ready, returns one-cycle result).
interface tlb_op_ctrl_if #(
  parameter int IDXW = 4
);
  logic            op_valid;
  logic            op_ready;
  logic [2:0]      op_code;
  logic [4:0]      op_inv_code;
  logic [9:0]      op_inv_asid;
  logic [18:0]     op_inv_vppn;
  logic [IDXW-1:0] csr_index;
  logic [88:0]     csr_entry;
  logic            res_valid;
  logic            res_found;
  logic [IDXW-1:0] res_index;
  logic [88:0]     res_entry;
  logic            res_ine;

  modport master (
    output op_valid, op_code, op_inv_code, op_inv_asid, op_inv_vppn, csr_index, csr_entry,
    input  op_ready, res_valid, res_found, res_index, res_entry, res_ine
  );

  modport slave (
    input  op_valid, op_code, op_inv_code, op_inv_asid, op_inv_vppn, csr_index, csr_entry,
    output op_ready, res_valid, res_found, res_index, res_entry, res_ine
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences tlbsrch/tlbrd/tlbwr/tlbfill/invtlb onto the tlb write, read, invtlb and
// search-port-1 interfaces. Latency: accept T, TLB action T+1, res_valid pulse T+2,
// ready again T+3. Backpressure: op_ready only in IDLE, so one op per 3 cycles.
// Ports: clk/reset; op (slave side of tlb_op_ctrl_if); lsu_s1_* LSU search key/grant;
// tlb_s1_* search port 1; tlb_we/tlb_w_* write port; tlb_r_* read port; tlb_inv_* invtlb.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  tlb_op_ctrl_if.slave    op,
  input  logic            lsu_s1_req,
  input  logic [18:0]     lsu_s1_vppn,
  input  logic            lsu_s1_va_bit12,
  input  logic [9:0]      lsu_s1_asid,
  output logic            lsu_s1_gnt,
  output logic [18:0]     tlb_s1_vppn,
  output logic            tlb_s1_va_bit12,
  output logic [9:0]      tlb_s1_asid,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [88:0]     tlb_w_entry,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [88:0]     tlb_r_entry,
  output logic            tlb_inv_valid,
  output logic [4:0]      tlb_inv_op,
  output logic [9:0]      tlb_inv_asid,
  output logic [18:0]     tlb_inv_vppn
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      code_q;
  logic [4:0]      inv_code_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_vppn_q;
  logic [IDXW-1:0] index_q;
  logic [88:0]     entry_q;
  logic [IDXW-1:0] fill_ptr;

  logic            res_valid_q, res_found_q, res_ine_q;
  logic [IDXW-1:0] res_index_q;
  logic [88:0]     res_entry_q;

  logic accept, exec, srch_exec, is_rd, is_wr, is_fill, is_inv, inv_legal, ine;

  assign accept    = op.op_valid && (state == IDLE);
  assign exec      = (state == EXEC);
  assign srch_exec = exec && (code_q == OP_SRCH);
  assign is_rd     = (code_q == OP_RD);
  assign is_wr     = (code_q == OP_WR);
  assign is_fill   = (code_q == OP_FILL);
  assign is_inv    = (code_q == OP_INV);
  assign inv_legal = (inv_code_q <= 5'd6);
  assign ine       = (code_q > OP_INV) || (is_inv && !inv_legal);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op.op_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept; held stable for the rest of the op.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q     <= '0;
      inv_code_q <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      index_q    <= '0;
      entry_q    <= '0;
    end else if (accept) begin
      code_q     <= op.op_code;
      inv_code_q <= op.op_inv_code;
      inv_asid_q <= op.op_inv_asid;
      inv_vppn_q <= op.op_inv_vppn;
      index_q    <= op.csr_index;
      entry_q    <= op.csr_entry;
    end
  end

  // Power-of-two TLBNUM: natural IDXW-bit wrap gives the mod-TLBNUM step.
  always_ff @(posedge clk) begin
    if (reset)                fill_ptr <= '0;
    else if (exec && is_fill) fill_ptr <= fill_ptr + IDXW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_index_q <= '0;
      res_entry_q <= '0;
      res_ine_q   <= 1'b0;
    end else begin
      res_valid_q <= exec;
      if (exec) begin
        res_found_q <= srch_exec && tlb_s1_found;
        res_index_q <= (srch_exec && tlb_s1_found) ? tlb_s1_index : '0;
        // An invalid entry (e=0) reads back as all zero.
        res_entry_q <= (is_rd && tlb_r_entry[88]) ? tlb_r_entry : '0;
        res_ine_q   <= ine;
      end
    end
  end

  assign op.op_ready  = (state == IDLE);
  assign op.res_valid = res_valid_q;
  assign op.res_found = res_found_q;
  assign op.res_index = res_index_q;
  assign op.res_entry = res_entry_q;
  assign op.res_ine   = res_ine_q;

  // Gating with reset makes a reset landing in EXEC abort the TLB side effect too.
  assign tlb_we        = exec && (is_wr || is_fill) && !reset;
  assign tlb_w_index   = is_fill ? fill_ptr : index_q;
  assign tlb_w_entry   = entry_q;
  assign tlb_r_index   = index_q;
  assign tlb_inv_valid = exec && is_inv && inv_legal && !reset;
  assign tlb_inv_op    = inv_code_q;
  assign tlb_inv_asid  = inv_asid_q;
  assign tlb_inv_vppn  = inv_vppn_q;

  // tlbsrch owns search port 1 for its single EXEC cycle; otherwise the LSU passes through.
  assign lsu_s1_gnt      = lsu_s1_req && !srch_exec;
  assign tlb_s1_vppn     = srch_exec ? entry_q[87:69] : lsu_s1_vppn;
  assign tlb_s1_va_bit12 = srch_exec ? 1'b0 : lsu_s1_va_bit12;
  assign tlb_s1_asid     = srch_exec ? entry_q[62:53] : lsu_s1_asid;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_op_ctrl_if #(.IDXW(4)) bus ();

  logic        lsu_s1_req;
  logic [18:0] lsu_s1_vppn;
  logic        lsu_s1_va_bit12;
  logic [9:0]  lsu_s1_asid;
  logic        lsu_s1_gnt;
  logic [18:0] tlb_s1_vppn;
  logic        tlb_s1_va_bit12;
  logic [9:0]  tlb_s1_asid;
  logic        tlb_s1_found;
  logic [3:0]  tlb_s1_index;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic [88:0] tlb_w_entry;
  logic [3:0]  tlb_r_index;
  logic [88:0] tlb_r_entry;
  logic        tlb_inv_valid;
  logic [4:0]  tlb_inv_op;
  logic [9:0]  tlb_inv_asid;
  logic [18:0] tlb_inv_vppn;

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset), .op(bus),
    .lsu_s1_req(lsu_s1_req), .lsu_s1_vppn(lsu_s1_vppn), .lsu_s1_va_bit12(lsu_s1_va_bit12),
    .lsu_s1_asid(lsu_s1_asid), .lsu_s1_gnt(lsu_s1_gnt),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
    .tlb_inv_asid(tlb_inv_asid), .tlb_inv_vppn(tlb_inv_vppn)
  );

  // Simple TLB model: full-vppn compare, global or asid match.
  logic [88:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (tlb_we) mem[tlb_w_index] <= tlb_w_entry;
    if (tlb_inv_valid) begin
      for (int i = 0; i < 16; i++) begin
        logic g, am, vm, clr;
        g  = mem[i][52];
        am = (mem[i][62:53] == tlb_inv_asid);
        vm = (mem[i][87:69] == tlb_inv_vppn);
        case (tlb_inv_op)
          5'd0, 5'd1: clr = 1'b1;
          5'd2:       clr = g;
          5'd3:       clr = !g;
          5'd4:       clr = !g && am;
          5'd5:       clr = !g && am && vm;
          5'd6:       clr = (g || am) && vm;
          default:    clr = 1'b0;
        endcase
        if (clr) mem[i][88] <= 1'b0;
      end
    end
  end

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = '0;
    for (int i = 0; i < 16; i++)
      if (mem[i][88] && mem[i][87:69] == tlb_s1_vppn && (mem[i][52] || mem[i][62:53] == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = i[3:0];
      end
  end
  assign tlb_r_entry = mem[tlb_r_index];

  int    n_chk  = 0;
  int    n_fail = 0;
  string cur    = "init";

  task automatic chk(input string name, input logic [88:0] act, input logic [88:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  inv_code;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic [3:0]  idx;
    logic [88:0] entry;
    logic        lsu;
    logic        exp_we;
    logic [3:0]  exp_widx;
    logic        exp_inv;
    logic        exp_found;
    logic [3:0]  exp_ridx;
    logic [88:0] exp_entry;
    logic        exp_ine;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] ic, input logic [9:0] ia,
                              input logic [18:0] iv, input logic [3:0] idx, input logic [88:0] en,
                              input logic lsu, input logic we, input logic [3:0] widx,
                              input logic inv, input logic fnd, input logic [3:0] ridx,
                              input logic [88:0] een, input logic ine);
    vec_t v;
    v.op = op; v.inv_code = ic; v.inv_asid = ia; v.inv_vppn = iv; v.idx = idx; v.entry = en;
    v.lsu = lsu; v.exp_we = we; v.exp_widx = widx; v.exp_inv = inv; v.exp_found = fnd;
    v.exp_ridx = ridx; v.exp_entry = een; v.exp_ine = ine;
    return v;
  endfunction

  localparam logic [18:0] LSU_VPPN = 19'h7ABCD;
  localparam logic [9:0]  LSU_ASID = 10'h155;

  task automatic run(input vec_t v);
    int n;
    n = 0;
    while (!bus.op_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", bus.op_ready, 1'b1);
    bus.op_valid = 1'b1; bus.op_code = v.op; bus.op_inv_code = v.inv_code;
    bus.op_inv_asid = v.inv_asid; bus.op_inv_vppn = v.inv_vppn;
    bus.csr_index = v.idx; bus.csr_entry = v.entry; lsu_s1_req = v.lsu;
    @(negedge clk);  // EXEC; scramble inputs while keeping op_valid high
    bus.op_code = ~v.op; bus.op_inv_code = ~v.inv_code; bus.op_inv_asid = ~v.inv_asid;
    bus.op_inv_vppn = ~v.inv_vppn; bus.csr_index = ~v.idx; bus.csr_entry = ~v.entry;
    #1;
    chk("ready_exec", bus.op_ready, 1'b0);
    chk("we", tlb_we, v.exp_we);
    if (v.exp_we) begin
      chk("w_index", tlb_w_index, v.exp_widx);
      chk("w_entry", tlb_w_entry, v.entry);
    end
    chk("inv_valid", tlb_inv_valid, v.exp_inv);
    if (v.exp_inv) begin
      chk("inv_op", tlb_inv_op, v.inv_code);
      chk("inv_asid", tlb_inv_asid, v.inv_asid);
      chk("inv_vppn", tlb_inv_vppn, v.inv_vppn);
    end
    chk("gnt_exec", lsu_s1_gnt, v.lsu && (v.op != 3'd0));
    if (v.op == 3'd0) begin
      chk("s1_vppn", tlb_s1_vppn, v.entry[87:69]);
      chk("s1_bit12", tlb_s1_va_bit12, 1'b0);
      chk("s1_asid", tlb_s1_asid, v.entry[62:53]);
    end
    chk("res_valid_exec", bus.res_valid, 1'b0);
    @(negedge clk);  // RESP
    chk("res_valid", bus.res_valid, 1'b1);
    chk("res_found", bus.res_found, v.exp_found);
    chk("res_index", bus.res_index, v.exp_ridx);
    chk("res_entry", bus.res_entry, v.exp_entry);
    chk("res_ine", bus.res_ine, v.exp_ine);
    chk("we_resp", tlb_we, 1'b0);
    chk("inv_resp", tlb_inv_valid, 1'b0);
    chk("gnt_resp", lsu_s1_gnt, v.lsu);
    if (v.lsu) chk("s1_pass", tlb_s1_vppn, LSU_VPPN);
    bus.op_valid = 1'b0;
    @(negedge clk);  // IDLE
    chk("res_valid_off", bus.res_valid, 1'b0);
    chk("ready_back", bus.op_ready, 1'b1);
  endtask

  vec_t vecs [13];
  logic [88:0] e1, e2, z;

  initial begin
    z  = '0;
    e1 = {1'b1, 19'h12345, 6'd12, 10'd3, 1'b0, 20'hABCDE, 2'd0, 2'd0, 1'b0, 1'b1,
          20'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    e2 = {1'b1, 19'h00777, 6'd12, 10'd4, 1'b1, 20'h11111, 2'd1, 2'd1, 1'b1, 1'b1,
          20'h22222, 2'd0, 2'd0, 1'b0, 1'b0};
    //            op    ic    ia     iv          idx   entry lsu we widx inv fnd ridx exp_entry ine
    vecs[0]  = mk(3'd3, 5'd0, 10'd0, 19'h0,      4'd9, z,  0, 1, 4'd0, 0, 0, 4'd0, z,  0);
    vecs[1]  = mk(3'd3, 5'd0, 10'd0, 19'h0,      4'd9, z,  0, 1, 4'd1, 0, 0, 4'd0, z,  0);
    vecs[2]  = mk(3'd3, 5'd0, 10'd0, 19'h0,      4'd9, z,  0, 1, 4'd2, 0, 0, 4'd0, z,  0);
    vecs[3]  = mk(3'd3, 5'd0, 10'd0, 19'h0,      4'd9, z,  0, 1, 4'd3, 0, 0, 4'd0, z,  0);
    vecs[4]  = mk(3'd2, 5'd0, 10'd0, 19'h0,      4'd5, e1, 0, 1, 4'd5, 0, 0, 4'd0, z,  0);
    vecs[5]  = mk(3'd0, 5'd0, 10'd0, 19'h0,      4'd0, e1, 1, 0, 4'd0, 0, 1, 4'd5, z,  0);
    vecs[6]  = mk(3'd1, 5'd0, 10'd0, 19'h0,      4'd5, z,  0, 0, 4'd0, 0, 0, 4'd0, e1, 0);
    vecs[7]  = mk(3'd1, 5'd0, 10'd0, 19'h0,      4'd9, z,  0, 0, 4'd0, 0, 0, 4'd0, z,  0);
    vecs[8]  = mk(3'd4, 5'd5, 10'd3, 19'h12345,  4'd0, z,  0, 0, 4'd0, 1, 0, 4'd0, z,  0);
    vecs[9]  = mk(3'd0, 5'd0, 10'd0, 19'h0,      4'd0, e1, 1, 0, 4'd0, 0, 0, 4'd0, z,  0);
    vecs[10] = mk(3'd4, 5'd9, 10'd3, 19'h12345,  4'd0, z,  0, 0, 4'd0, 0, 0, 4'd0, z,  1);
    vecs[11] = mk(3'd7, 5'd0, 10'd0, 19'h0,      4'd5, e1, 1, 0, 4'd0, 0, 0, 4'd0, z,  1);
    vecs[12] = mk(3'd1, 5'd0, 10'd0, 19'h0,      4'd5, z,  0, 0, 4'd0, 0, 0, 4'd0, z,  0);

    reset = 1'b1;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_inv_code = '0; bus.op_inv_asid = '0;
    bus.op_inv_vppn = '0; bus.csr_index = '0; bus.csr_entry = '0;
    lsu_s1_req = 1'b0; lsu_s1_vppn = LSU_VPPN; lsu_s1_va_bit12 = 1'b1; lsu_s1_asid = LSU_ASID;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    cur = "reset";
    chk("op_ready", bus.op_ready, 1'b1);
    chk("res_valid", bus.res_valid, 1'b0);
    chk("res_entry", bus.res_entry, z);
    chk("res_ine", bus.res_ine, 1'b0);
    chk("we", tlb_we, 1'b0);
    chk("inv_valid", tlb_inv_valid, 1'b0);
    chk("gnt", lsu_s1_gnt, 1'b0);

    for (int i = 0; i < 13; i++) begin
      cur = $sformatf("vec%0d", i);
      run(vecs[i]);
    end

    // Fills 4..15 then wrap back to 0.
    for (int i = 4; i < 17; i++) begin
      cur = $sformatf("fill%0d", i);
      run(mk(3'd3, 5'd0, 10'd0, 19'h0, 4'd9, z, 0, 1, 4'(i % 16), 0, 0, 4'd0, z, 0));
    end

    // Reset landing in the EXEC cycle of a wr.
    cur = "midreset";
    bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.csr_index = 4'd7; bus.csr_entry = e2;
    @(negedge clk);
    reset = 1'b1; bus.op_valid = 1'b0;
    #1;
    chk("we", tlb_we, 1'b0);
    chk("inv_valid", tlb_inv_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("res_valid", bus.res_valid, 1'b0);
    chk("op_ready", bus.op_ready, 1'b1);
    chk("we_after", tlb_we, 1'b0);
    @(negedge clk);
    chk("res_valid_late", bus.res_valid, 1'b0);
    cur = "fill_after_reset";
    run(mk(3'd3, 5'd0, 10'd0, 19'h0, 4'd9, z, 0, 1, 4'd0, 0, 0, 4'd0, z, 0));
    cur = "rd_aborted_wr";
    run(mk(3'd1, 5'd0, 10'd0, 19'h0, 4'd7, z, 0, 0, 4'd0, 0, 0, 4'd0, z, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
